// File: rtl/regfile_dp.sv
// -----------------------------------------------------------------------------
// regfile_dp
// Parametrised register file with two read ports and one write port. It sits
// between the operand register (OR2), the ALU result bus and the ALU input
// latches.
//
// The write data source is selected combinationally by wr_src:
//   00 OR2, 01 ALU_IN, 10 imm_in, 11 mem[wr_addr] +1/-1 (chosen by inc_dir).
// Both read ports are registered, so reads have one cycle of latency.
// rd_valid marks the cycle after an accepted read. A read of the address
// being written in the same cycle returns the new write data (bypass).
// Out-of-range addresses, and register 0 when ZERO_REG=1, read as zero.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   wr_en, wr_addr        write strobe and target register
//   wr_src, inc_dir       write data select; +1 / -1 for wr_src=11
//   OR2, ALU_IN, imm_in   write data sources
//   rd_en                 read strobe, shared by both ports
//   rd_addr_a, rd_addr_b  read addresses
//   dataout_A, dataout_B  registered read data
//   rd_valid              high the cycle after an accepted read
//   z_flag                last committed write data was zero
//   wr_err                one-cycle pulse for a write to an out-of-range address
// -----------------------------------------------------------------------------
module regfile_dp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_src,
  input  logic              inc_dir,
  input  logic [DATA_W-1:0] OR2,
  input  logic [DATA_W-1:0] ALU_IN,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] dataout_A,
  output logic [DATA_W-1:0] dataout_B,
  output logic              rd_valid,
  output logic              z_flag,
  output logic              wr_err
);

  // The whole address space is decoded. Slots that have no physical register
  // (beyond NUM_REGS, or a hardwired register 0) are tied to zero. Reads then
  // need no separate range check.
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_in_range;
  logic              wr_blocked;
  logic              wr_commit;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a_next;
  logic [DATA_W-1:0] rd_b_next;

  logic [DATA_W-1:0] dataout_a_reg;
  logic [DATA_W-1:0] dataout_b_reg;
  logic              rd_valid_reg;
  logic              z_flag_reg;
  logic              wr_err_reg;

  // The compare is one bit wider, so NUM_REGS == 2**ADDR_W is representable.
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS));
  // A write to a hardwired register 0 is silently dropped. It is not an error.
  assign wr_blocked  = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_commit   = wr_en && wr_in_range && !wr_blocked;

  // wr_old is the current contents of the write target, for in-place inc/dec.
  assign wr_old = mem_q[wr_addr];

  always_comb begin
    wr_data = OR2;
    case (wr_src)
      2'b00:   wr_data = OR2;
      2'b01:   wr_data = ALU_IN;
      2'b10:   wr_data = imm_in;
      default: wr_data = inc_dir ? (wr_old - DATA_W'(1)) : (wr_old + DATA_W'(1));
    endcase
  end

  // Register storage. Each slot is its own register with async reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      if ((gi < NUM_REGS) && !((ZERO_REG != 0) && (gi == 0))) begin : g_reg
        logic [DATA_W-1:0] r_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_reg <= '0;
          end else if (wr_commit && (wr_addr == ADDR_W'(gi))) begin
            r_reg <= wr_data;
          end
        end
        assign mem_q[gi] = r_reg;
      end else begin : g_const
        assign mem_q[gi] = '0;
      end
    end
  endgenerate

  // Bypass: wr_commit is never true for a dropped or out-of-range write. That
  // keeps hardwired and unimplemented slots reading as zero.
  assign rd_a_next = (wr_commit && (rd_addr_a == wr_addr)) ? wr_data : mem_q[rd_addr_a];
  assign rd_b_next = (wr_commit && (rd_addr_b == wr_addr)) ? wr_data : mem_q[rd_addr_b];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout_a_reg <= '0;
      dataout_b_reg <= '0;
      rd_valid_reg  <= 1'b0;
      z_flag_reg    <= 1'b0;
      wr_err_reg    <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        dataout_a_reg <= rd_a_next;
        dataout_b_reg <= rd_b_next;
      end
      wr_err_reg <= wr_en && !wr_in_range;
      if (wr_commit) begin
        z_flag_reg <= (wr_data == '0);
      end
    end
  end

  assign dataout_A = dataout_a_reg;
  assign dataout_B = dataout_b_reg;
  assign rd_valid  = rd_valid_reg;
  assign z_flag    = z_flag_reg;
  assign wr_err    = wr_err_reg;

endmodule
